// File: rtl/lif_pkg.sv
// Shared types, defaults and the LIF update step for the sweep scheduler.
// Exports: state_t (IDLE/SWEEP), LIF_THRESHOLD, LIF_LEAK_SHIFT, lif_step().
package lif_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   localparam int LIF_THRESHOLD  = 200;
   localparam int LIF_LEAK_SHIFT = 3;

   // Returns {spike, v_next}. The leak never underflows because
   // v >> shift <= v; the sum is held at 9 bits to catch overflow.
   function automatic logic [8:0] lif_step(
      input logic [7:0] v,
      input logic [7:0] cur,
      input logic [7:0] thr,
      input logic [2:0] shift
   );
      logic [7:0] vl;
      logic [8:0] sum;
      vl  = v - (v >> shift);
      sum = {1'b0, vl} + {1'b0, cur};
      if (sum >= {1'b0, thr}) begin
         return {1'b1, 8'd0};
      end
      return {1'b0, sum[7:0]};
   endfunction

endpackage

// File: rtl/lif_spike_fifo.sv
// Small spike FIFO with a registered head word (DEPTH power of two, >= 2).
// Ports: clk, rst_i (sync, high), push_i/data_i/full_o, pop_i/empty_o, head_o.
module lif_spike_fifo
   import lif_pkg::*;
#(
   parameter int W     = 3,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   output logic         full_o,
   input  logic         pop_i,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW-1:0] rd_nxt;
   logic [AW:0]   cnt_q;
   logic [W-1:0]  head_q;
   logic [W-1:0]  head_d;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = head_q;

   // The head register always mirrors mem_q[rd_q] while non-empty,
   // so the consumer sees a flop output rather than a read mux.
   always_comb begin
      push_ok = push_i && !full_o;
      pop_ok  = pop_i && !empty_o;
      rd_nxt  = rd_q + 1'b1;
      head_d  = head_q;
      if (pop_ok) begin
         if (cnt_q > (AW+1)'(1)) begin
            head_d = mem_q[rd_nxt];
         end else if (push_ok) begin
            head_d = data_i;
         end
      end else if (empty_o && push_ok) begin
         head_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_q <= rd_nxt;
         end
         cnt_q  <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
         head_q <= head_d;
      end
   end

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed LIF scheduler: one datapath sweeps N_NEURONS states per tick.
// Ports: clk, rst, tick, cur_idx/cur_in, spike_valid/ready/idx, busy, overrun, dbg_sel/state.
module lif_sweep_scheduler
   import lif_pkg::*;
#(
   parameter int N_NEURONS  = 8,
   parameter int THRESHOLD  = LIF_THRESHOLD,
   parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
   parameter int FIFO_DEPTH = 4,
   localparam int IW        = $clog2(N_NEURONS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   output logic [IW-1:0] cur_idx,
   input  logic [7:0]    cur_in,
   output logic          spike_valid,
   input  logic          spike_ready,
   output logic [IW-1:0] spike_idx,
   output logic          busy,
   output logic          overrun,
   input  logic [IW-1:0] dbg_sel,
   output logic [7:0]    dbg_state
);

   localparam logic [7:0]    THR8  = 8'(THRESHOLD);
   localparam logic [2:0]    SH3   = 3'(LEAK_SHIFT);
   localparam logic [IW-1:0] LASTI = IW'(N_NEURONS - 1);

   state_t        state_q;
   logic [IW-1:0] idx_q;
   logic [7:0]    st_q [N_NEURONS];
   logic          ovr_q;

   logic [8:0]    step;
   logic          fire;
   logic          stall;
   logic          commit;
   logic          push;
   logic          fifo_full;
   logic          fifo_empty;

   // Stall uses the count before any same-cycle pop, so a full
   // FIFO holds the sweep for at least one cycle.
   always_comb begin
      step   = lif_step(st_q[idx_q], cur_in, THR8, SH3);
      fire   = (state_q == SWEEP) && step[8];
      stall  = fire && fifo_full;
      commit = (state_q == SWEEP) && !stall;
      push   = fire && !stall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            st_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tick) begin
                  state_q <= SWEEP;
                  idx_q   <= '0;
               end
            end
            SWEEP: begin
               if (tick) begin
                  ovr_q <= 1'b1;
               end
               if (commit) begin
                  st_q[idx_q] <= step[7:0];
                  if (idx_q == LASTI) begin
                     state_q <= IDLE;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = (state_q == SWEEP);
   assign cur_idx     = idx_q;
   assign overrun     = ovr_q;
   assign dbg_state   = st_q[dbg_sel];
   assign spike_valid = !fifo_empty;

   lif_spike_fifo #(
      .W     (IW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_i   (rst),
      .push_i  (push),
      .data_i  (idx_q),
      .full_o  (fifo_full),
      .pop_i   (spike_ready),
      .empty_o (fifo_empty),
      .head_o  (spike_idx)
   );

endmodule

// File: doc/lif_sweep_scheduler.md
# lif_sweep_scheduler

Time-multiplexed scheduler that shares one LIF update datapath across `N_NEURONS` virtual neurons. Membrane states are held in an internal register file. Each `tick` starts one sweep that updates every neuron in index order. Spikes are queued in a small FIFO and leave the block as address-event (AER) words over a valid/ready handshake. It sits between the current-input source and the spike consumer, in place of replicated per-neuron `lif` instances.

## Interface
Parameters:
- `N_NEURONS`, default 8: number of virtual neurons; must be a power of two, 2..32.
- `THRESHOLD`, default 200: 8-bit firing threshold.
- `LEAK_SHIFT`, default 3: leak term is `v >> LEAK_SHIFT`; range 1..7.
- `FIFO_DEPTH`, default 4: spike FIFO entries; must be a power of two.

Ports (`IW = $clog2(N_NEURONS)`):
- `clk`, input, 1: clock. One clock domain; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `tick`, input, 1: single-cycle pulse that requests one sweep.
- `cur_idx`, output, IW: index of the neuron whose current is being requested.
- `cur_in`, input, 8: input current for `cur_idx`; sampled in the same cycle.
- `spike_valid`, output, 1: FIFO head is valid.
- `spike_ready`, input, 1: consumer accepts the head.
- `spike_idx`, output, IW: neuron index of the FIFO head.
- `busy`, output, 1: a sweep is in progress.
- `overrun`, output, 1: sticky flag; a `tick` arrived while `busy`.
- `dbg_sel`, input, IW: selects one membrane state for debug readback.
- `dbg_state`, output, 8: membrane state of neuron `dbg_sel`; combinational read.

## Operation
- FSM states: `IDLE` and `SWEEP`.
  - `IDLE` → `SWEEP` on `tick`; `idx` is cleared to 0.
  - `SWEEP` → `IDLE` after the update of neuron `N_NEURONS-1` commits.
- Per-neuron update, in `SWEEP`, for `v = state[idx]`:
  - `vl = v - (v >> LEAK_SHIFT)` (8-bit, never underflows).
  - `sum = vl + cur_in`, computed at 9 bits.
  - If `sum >= THRESHOLD`: spike. `state[idx] <= 0` and `idx` is pushed to the FIFO.
  - Else: `state[idx] <= sum[7:0]`. Since `sum < THRESHOLD <= 255`, no saturation is needed.
- Stall rule:
  - Applies when the neuron would spike and the FIFO count equals `FIFO_DEPTH`, evaluated before any pop in that cycle.
  - During a stall the state is not written and `idx` does not advance; `cur_idx` holds.
  - The update is re-evaluated each cycle with the current `cur_in`.
- Non-spiking updates never stall.
- `cur_idx` equals `idx` in `SWEEP` and 0 in `IDLE`.
- `tick` while `busy`: ignored, and sets `overrun`. `overrun` is cleared only by `rst`.
- `tick` in the same cycle the last update commits: ignored, and sets `overrun` (`busy` is still 1 in that cycle).
- FIFO behaviour:
  - Pop happens when `spike_valid && spike_ready`.
  - Push and pop in the same cycle are both allowed when not full.
  - Spike ordering is preserved: ascending index within a sweep, then sweep order.
- `dbg_sel >= N_NEURONS` cannot occur because `N_NEURONS` is a power of two.

## Timing
- Reset values:
  - All membrane states 0 and FIFO empty.
  - FSM in `IDLE`, `idx` 0.
  - Outputs: `busy`=0, `overrun`=0, `spike_valid`=0, `spike_idx`=0, `cur_idx`=0.
- `tick` sampled high in cycle t (in `IDLE`):
  - `busy`=1 from cycle t+1.
  - Neuron i is updated in cycle t+1+i, with no stalls.
  - `busy`=0 in cycle t+1+N_NEURONS.
- Each stall cycle adds exactly one cycle to the sweep.
- Spike pushed at the end of cycle c:
  - If the FIFO was empty, `spike_valid`=1 in cycle c+1, with `spike_idx` registered.
- Once `spike_valid` is 1, `spike_valid` and `spike_idx` must stay stable until accepted.
- `rst` asserted mid-sweep: at the next edge everything returns to reset values; queued spikes are discarded.

## Structure
- Package `lif_pkg` holds:
  - the `state_t` enum (`IDLE`, `SWEEP`);
  - default constants `LIF_THRESHOLD` and `LIF_LEAK_SHIFT`;
  - the pure function `lif_step(v, cur, thr, shift)`, which returns `{spike, v_next}`.
- Sub-module `lif_spike_fifo`:
  - parameterised width and depth;
  - sync reset, `push`/`full`, `pop`/`empty`, and a registered head.
- Top level contains the FSM, the `idx` counter, the state register file and the overrun flag.

## Test plan
All scenarios use default parameters.
- Reset, then `tick` with `cur_in`=100 for all neurons, `spike_ready`=1:
  - `busy` is high for exactly 8 cycles;
  - all `dbg_state` values are 100;
  - no spikes.
- Two more ticks at `cur_in`=100:
  - after sweep 2, states are 188 (100-12+100);
  - sweep 3 gives 188-23+100=265, so all 8 neurons spike;
  - AER order is 0..7, and all states return to 0.
- Repeat the 3-sweep sequence with `spike_ready`=0:
  - 4 spikes queue (idx 0..3);
  - the sweep stalls at `cur_idx`=4 with `busy` held;
  - raising `spike_ready` drains the FIFO and the sweep completes;
  - all 8 indices are delivered in order.
- `tick` at cycle t+3 during a sweep:
  - `overrun`=1 and stays set;
  - the sweep length is unchanged;
  - no second sweep starts.
- `cur_in`=255 to a neuron at state 0:
  - spikes on the first sweep, since 255 ≥ 200;
  - `cur_in`=199 from state 0 does not spike (state becomes 199).
- `rst` pulsed mid-sweep with a non-empty FIFO:
  - next cycle `busy`=0 and `spike_valid`=0;
  - all `dbg_state` values are 0.
